// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared state and grant-source types for the instruction-memory arbiter
package imem_arb_pkg;
  typedef enum logic [1:0] {ARB_RUN, ARB_DRAIN, ARB_HALTED} arb_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_F, SRC_L} src_t;
endpackage

// File: rtl/imem_arb_starve_cnt.sv
// imem_arb_starve_cnt: saturating count of loader wait cycles; force_l when it reaches STARVE_MAX
//   in: clk, rst_n, l_req, l_gnt   out: force_l
module imem_arb_starve_cnt #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic l_req,
  input  logic l_gnt,
  output logic force_l
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!l_req || l_gnt) ? '0 : (cnt == MAX) ? cnt : cnt + 1'b1;
  assign force_l = cnt == MAX;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port instruction RAM between CPU fetch (F) and loader/debug port (L)
//   F: f_req/f_addr/f_flush -> f_gnt/f_rvalid/f_rdata   L: l_req/l_we/l_addr/l_wdata -> l_gnt/l_rvalid/l_rdata
//   halt_req -> halt_ack (exclusive L access)   RAM: m_en/m_we/m_addr/m_wdata, m_rdata (1-cycle latency)
//   IMEM_ARB_STATS_EN adds f_wait_cnt and l_xfer_cnt outputs
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]       f_wait_cnt,
  output logic [31:0]       l_xfer_cnt
`endif
);
  arb_state_t state;
  src_t src;
  logic force_l, f_pend, f_kill, l_pend;
  logic [DATA_W-1:0] f_hold, l_hold;
  logic unused_addr;
  assign unused_addr = ^{f_addr[31:ADDR_W+2], f_addr[1:0]};
  // grants are forced low while reset is asserted so the RAM is never enabled during reset
  assign src = !rst_n ? SRC_NONE
             : (state == ARB_RUN && f_req && !(force_l && l_req)) ? SRC_F
             : l_req ? SRC_L : SRC_NONE;
  assign f_gnt   = src == SRC_F;
  assign l_gnt   = src == SRC_L;
  assign m_en    = f_gnt || l_gnt;
  assign m_we    = l_gnt && l_we;
  assign m_addr  = l_gnt ? l_addr : f_addr[ADDR_W+1:2];
  assign m_wdata = l_wdata;
  imem_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk), .rst_n(rst_n), .l_req(l_req), .l_gnt(l_gnt), .force_l(force_l)
  );
  // DRAIN never grants F and the only read that can be in flight returns during the
  // single DRAIN cycle, so HALTED always follows one cycle later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ARB_RUN;
      halt_ack <= 1'b0;
    end else if (state == ARB_RUN) begin
      state    <= halt_req ? ARB_DRAIN : ARB_RUN;
      halt_ack <= 1'b0;
    end else begin
      state    <= halt_req ? ARB_HALTED : ARB_RUN;
      halt_ack <= halt_req;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f_pend <= 1'b0;
      f_kill <= 1'b0;
      l_pend <= 1'b0;
      f_hold <= '0;
      l_hold <= '0;
    end else begin
      f_pend <= f_gnt;
      f_kill <= f_gnt && f_flush;
      l_pend <= l_gnt && !l_we;
      if (f_pend) f_hold <= m_rdata;
      if (l_pend) l_hold <= m_rdata;
    end
  // response data comes straight from the RAM output register and is held afterwards
  assign f_rvalid = f_pend && !f_kill && !f_flush;
  assign l_rvalid = l_pend;
  assign f_rdata  = f_pend ? m_rdata : f_hold;
  assign l_rdata  = l_pend ? m_rdata : l_hold;
`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f_wait_cnt <= '0;
      l_xfer_cnt <= '0;
    end else begin
      f_wait_cnt <= f_wait_cnt + 32'(f_req && !f_gnt);
      l_xfer_cnt <= l_xfer_cnt + 32'(l_gnt);
    end
`endif
endmodule
